cursor: RTL and testbench

CURSOR -- requirements
Module: cursor

---
 rtl/vga_pkg.sv | 8 +
 rtl/cursor.sv | 48 ++++
 tb/tb_cursor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA display path: pixel clock rate and the
// cursor blink half-period expressed in pixel-clock cycles.
package vga_pkg;

  localparam int unsigned PIX_CLK_HZ         = 25_000_000;
  localparam int unsigned CURSOR_HALF_PERIOD = PIX_CLK_HZ / 2;

endpackage : vga_pkg

// File: rtl/cursor.sv
// Text-cursor blink generator: flash_on toggles every HALF_PERIOD cycles while
// enabled, restart forces a fresh visible phase, tick pulses on every toggle.
module cursor
  import vga_pkg::*;
#(
  parameter int unsigned HALF_PERIOD   = CURSOR_HALF_PERIOD,
  parameter bit          START_VISIBLE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic flash_on,
  output logic tick
);

  localparam int unsigned CW = $clog2(HALF_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  // Branch order encodes priority: rst, restart, disable, then count/wrap.
  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see updated values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      flash_on <= START_VISIBLE;
      tick     <= 1'b0;
    end else if (restart) begin
      cnt      <= '0;
      flash_on <= 1'b1;
      tick     <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      flash_on <= 1'b0;
      tick     <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      flash_on <= ~flash_on;
      tick     <= 1'b1;
    end else begin
      cnt      <= cnt + CW'(1);
      tick     <= 1'b0;
    end
  end

endmodule : cursor

// File: tb/tb_cursor.sv
// Directed bench for cursor: vector table on HALF_PERIOD=4, plus hand
// sequences for steady blink, HALF_PERIOD=1 and START_VISIBLE=1.
module tb_cursor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic restart = 1'b0;
  logic flash_on, tick;
  logic flash_1, tick_1;
  logic flash_v, tick_v;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cursor #(.HALF_PERIOD(4), .START_VISIBLE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .flash_on(flash_on), .tick(tick)
  );

  cursor #(.HALF_PERIOD(1), .START_VISIBLE(1'b0)) dut_hp1 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .flash_on(flash_1), .tick(tick_1)
  );

  cursor #(.HALF_PERIOD(4), .START_VISIBLE(1'b1)) dut_vis (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .flash_on(flash_v), .tick(tick_v)
  );

  typedef struct {
    logic rst;
    logic en;
    logic restart;
    logic exp_flash;
    logic exp_tick;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic s,
                              input logic f, input logic t, input int c);
    vec_t v;
    v.rst = r; v.en = e; v.restart = s;
    v.exp_flash = f; v.exp_tick = t; v.exp_cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, and return
  // at the next falling edge so outputs are sampled away from the clock edge.
  task automatic step(input logic r, input logic e, input logic s);
    rst = r; en = e; restart = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ticks;
    int model_cnt;
    logic model_flash;
    logic prev_tick;
    logic exp1;

    //   rst en rs  flash tick cnt
    add(1, 1, 0,   0, 0, 0);   // reset held 3 cycles with en=1
    add(1, 1, 0,   0, 0, 0);
    add(1, 1, 0,   0, 0, 0);
    add(0, 1, 0,   0, 0, 1);
    add(0, 1, 0,   0, 0, 2);
    add(0, 1, 0,   0, 0, 3);
    add(0, 1, 0,   1, 1, 0);   // 4th edge after release: first toggle
    add(0, 1, 0,   1, 0, 1);
    add(0, 1, 0,   1, 0, 2);
    add(0, 1, 0,   1, 0, 3);
    add(0, 1, 0,   0, 1, 0);
    add(0, 1, 0,   0, 0, 1);
    add(0, 1, 0,   0, 0, 2);
    add(0, 1, 1,   1, 0, 0);   // restart at cnt=2 with flash_on=0
    add(0, 1, 0,   1, 0, 1);
    add(0, 1, 0,   1, 0, 2);
    add(0, 1, 0,   1, 0, 3);
    add(0, 1, 0,   0, 1, 0);   // first toggle 4 cycles after restart
    add(0, 1, 0,   0, 0, 1);
    add(0, 1, 0,   0, 0, 2);
    add(0, 1, 0,   0, 0, 3);
    add(0, 1, 1,   1, 0, 0);   // restart coinciding with wrap
    add(0, 0, 0,   0, 0, 0);   // disabled for 5 cycles
    add(0, 0, 0,   0, 0, 0);
    add(0, 0, 0,   0, 0, 0);
    add(0, 0, 0,   0, 0, 0);
    add(0, 0, 0,   0, 0, 0);
    add(0, 1, 0,   0, 0, 1);   // re-enable
    add(0, 1, 0,   0, 0, 2);
    add(0, 1, 0,   0, 0, 3);
    add(0, 1, 0,   1, 1, 0);
    add(0, 0, 1,   1, 0, 0);   // restart beats en=0
    add(0, 0, 0,   0, 0, 0);
    add(1, 0, 1,   0, 0, 0);   // rst beats restart
    add(0, 1, 0,   0, 0, 1);
    add(0, 1, 0,   0, 0, 2);
    add(1, 1, 0,   0, 0, 0);   // mid-period reset discards count
    add(0, 1, 0,   0, 0, 1);
    add(0, 1, 0,   0, 0, 2);
    add(0, 1, 0,   0, 0, 3);
    add(0, 1, 0,   1, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].restart);
      check($sformatf("vec%0d flash_on", i), int'(flash_on), int'(vecs[i].exp_flash));
      check($sformatf("vec%0d tick", i), int'(tick), int'(vecs[i].exp_tick));
      check($sformatf("vec%0d cnt", i), int'(dut.cnt), vecs[i].exp_cnt);
    end

    // Reset-value checks for the parameter variants.
    step(1, 1, 0);
    check("vis reset flash_on", int'(flash_v), 1);
    check("vis reset tick", int'(tick_v), 0);
    check("hp1 reset flash_on", int'(flash_1), 0);
    check("hp1 reset tick", int'(tick_1), 0);

    // HALF_PERIOD=1: toggles every cycle with tick held high.
    exp1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 0);
      exp1 = ~exp1;
      check($sformatf("hp1 cyc%0d flash_on", c), int'(flash_1), int'(exp1));
      check($sformatf("hp1 cyc%0d tick", c), int'(tick_1), 1);
      check($sformatf("hp1 cyc%0d cnt", c), int'(dut_hp1.cnt), 0);
    end

    // Steady blink for 40 cycles from reset on the main instance.
    step(1, 1, 0);
    ticks = 0;
    model_cnt = 0;
    model_flash = 1'b0;
    prev_tick = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(0, 1, 0);
      if (model_cnt == 3) begin
        model_cnt = 0;
        model_flash = ~model_flash;
      end else begin
        model_cnt++;
      end
      check($sformatf("blink cyc%0d flash_on", c), int'(flash_on), int'(model_flash));
      if (tick) ticks++;
      if (tick && prev_tick) check($sformatf("blink cyc%0d tick width", c), 2, 1);
      if (int'(dut.cnt) > 3) check($sformatf("blink cyc%0d cnt bound", c), int'(dut.cnt), 3);
      prev_tick = tick;
    end
    check("blink tick count", ticks, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cursor
